// File: rtl/ingress_wrreq_regbank.sv
// ingress_wrreq_regbank
//   Per-channel register bank fed by the ingress write-request parser.
//   Stores SG-buffer length/low-address per (direction, channel) and the RX
//   transfer length per channel. Doorbell writes (SG high address, RX
//   offset/last) turn the stored registers into events that are queued
//   toward the TX/RX action modules. The parser cannot be stalled, so the
//   bank never back-pressures; events are only lost on queue overflow.
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   wr_req/wr_tdest/wr_tdata : single-cycle write strobe, {code, action, channel}, data
//   sg_evt_*              : SG-descriptor event queue head (valid/rdy handshake)
//   rx_evt_*              : RX-transfer event queue head (valid/rdy handshake)
//   drop_cnt              : ignored writes plus overflowed events, saturating
//   ovf_sticky            : any event-queue overflow since reset

// Small FIFO used for both event queues. The head is always mem[rd_ptr], so
// there is no path from push to the outputs.
module ingress_wrreq_evq #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             rdy,
    output logic             valid,
    output logic [WIDTH-1:0] head,
    output logic             overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW:0]      count_reg;
    logic             pop;
    logic             full;
    logic             accept;

    assign valid    = (count_reg != '0);
    assign pop      = valid & rdy;
    assign full     = (count_reg == (AW+1)'(DEPTH));
    // A full queue still takes a push when its head leaves in the same cycle.
    assign accept   = push & (~full | pop);
    assign overflow = push & ~accept;
    assign head     = mem_reg[rd_ptr_reg];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (accept) begin
                mem_reg[wr_ptr_reg] <= push_data;
                wr_ptr_reg          <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({accept, pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: ;
            endcase
        end
    end
endmodule

module ingress_wrreq_regbank #(
    parameter int CHANNEL_NUM = 16,
    parameter int EVQ_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_req,
    input  logic [9:0]  wr_tdest,
    input  logic [31:0] wr_tdata,
    output logic        sg_evt_valid,
    input  logic        sg_evt_rdy,
    output logic        sg_evt_dir,
    output logic [3:0]  sg_evt_chn,
    output logic [63:0] sg_evt_addr,
    output logic [31:0] sg_evt_len,
    output logic        rx_evt_valid,
    input  logic        rx_evt_rdy,
    output logic [3:0]  rx_evt_chn,
    output logic [31:0] rx_evt_len,
    output logic [30:0] rx_evt_offset,
    output logic        rx_evt_last,
    output logic [15:0] drop_cnt,
    output logic        ovf_sticky
);
    localparam int SG_W = 1 + 4 + 64 + 32;
    localparam int RX_W = 4 + 32 + 31 + 1;

    localparam logic [2:0] CODE_XFER_LEN = 3'b000;
    localparam logic [2:0] CODE_OFS_LAST = 3'b001;
    localparam logic [2:0] CODE_SG_LEN   = 3'b011;
    localparam logic [2:0] CODE_SG_LO    = 3'b100;
    localparam logic [2:0] CODE_SG_HI    = 3'b101;

    logic [3:0] wr_chn;
    logic [1:0] wr_act;
    logic [2:0] wr_code;
    logic       wr_dir;
    logic       addr_ok;
    logic       code_ok;
    logic       wr_valid;
    logic       wr_ignored;
    logic       tdest_unused;

    assign wr_chn       = wr_tdest[3:0];
    assign wr_act       = wr_tdest[5:4];
    assign wr_code      = wr_tdest[8:6];
    assign wr_dir       = wr_act[0];
    assign tdest_unused = wr_tdest[9];

    assign addr_ok = ~wr_act[1] & (int'(wr_chn) < CHANNEL_NUM);

    always_comb begin
        code_ok = 1'b0;
        case (wr_code)
            CODE_SG_LEN, CODE_SG_LO, CODE_SG_HI: code_ok = 1'b1;
            CODE_XFER_LEN, CODE_OFS_LAST:        code_ok = wr_dir;  // RX only
            default:                             code_ok = 1'b0;
        endcase
    end

    assign wr_valid   = wr_req & addr_ok & code_ok;
    assign wr_ignored = wr_req & ~(addr_ok & code_ok);

    // Per-channel storage, flattened for the doorbell read mux.
    logic [31:0] sg_len_q   [CHANNEL_NUM][2];
    logic [31:0] sg_lo_q    [CHANNEL_NUM][2];
    logic [31:0] xfer_len_q [CHANNEL_NUM];

    for (genvar gi = 0; gi < CHANNEL_NUM; gi++) begin : g_chn
        logic [31:0] sg_len_reg [2];
        logic [31:0] sg_lo_reg  [2];
        logic [31:0] xfer_len_reg;
        logic        hit;

        assign hit = wr_valid & (wr_chn == 4'(gi));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sg_len_reg[0] <= '0;
                sg_len_reg[1] <= '0;
                sg_lo_reg[0]  <= '0;
                sg_lo_reg[1]  <= '0;
                xfer_len_reg  <= '0;
            end else if (hit) begin
                case (wr_code)
                    CODE_SG_LEN:   sg_len_reg[wr_dir] <= wr_tdata;
                    CODE_SG_LO:    sg_lo_reg[wr_dir]  <= wr_tdata;
                    CODE_XFER_LEN: xfer_len_reg       <= wr_tdata;
                    default:       ;
                endcase
            end
        end

        assign sg_len_q[gi]   = sg_len_reg;
        assign sg_lo_q[gi]    = sg_lo_reg;
        assign xfer_len_q[gi] = xfer_len_reg;
    end

    // Doorbells read the registered values, i.e. what was stored before
    // this cycle; a write one cycle earlier is therefore already visible.
    logic [31:0] sg_len_sel;
    logic [31:0] sg_lo_sel;
    logic [31:0] xfer_len_sel;

    always_comb begin
        sg_len_sel   = '0;
        sg_lo_sel    = '0;
        xfer_len_sel = '0;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            if (wr_chn == 4'(i)) begin
                sg_len_sel   = sg_len_q[i][wr_dir];
                sg_lo_sel    = sg_lo_q[i][wr_dir];
                xfer_len_sel = xfer_len_q[i];
            end
        end
    end

    logic            sg_push;
    logic            rx_push;
    logic [SG_W-1:0] sg_push_data;
    logic [RX_W-1:0] rx_push_data;
    logic [SG_W-1:0] sg_head;
    logic [RX_W-1:0] rx_head;
    logic            sg_ovf;
    logic            rx_ovf;

    assign sg_push      = wr_valid & (wr_code == CODE_SG_HI);
    assign rx_push      = wr_valid & (wr_code == CODE_OFS_LAST);
    assign sg_push_data = {wr_dir, wr_chn, wr_tdata, sg_lo_sel, sg_len_sel};
    assign rx_push_data = {wr_chn, xfer_len_sel, wr_tdata[30:0], wr_tdata[31]};

    ingress_wrreq_evq #(.WIDTH(SG_W), .DEPTH(EVQ_DEPTH)) u_sg_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (sg_push),
        .push_data (sg_push_data),
        .rdy       (sg_evt_rdy),
        .valid     (sg_evt_valid),
        .head      (sg_head),
        .overflow  (sg_ovf)
    );

    ingress_wrreq_evq #(.WIDTH(RX_W), .DEPTH(EVQ_DEPTH)) u_rx_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rx_push),
        .push_data (rx_push_data),
        .rdy       (rx_evt_rdy),
        .valid     (rx_evt_valid),
        .head      (rx_head),
        .overflow  (rx_ovf)
    );

    assign {sg_evt_dir, sg_evt_chn, sg_evt_addr, sg_evt_len}       = sg_head;
    assign {rx_evt_chn, rx_evt_len, rx_evt_offset, rx_evt_last}    = rx_head;

    // One write per cycle means at most one of these can be set at once.
    logic        drop_inc;
    logic [15:0] drop_cnt_reg;
    logic        ovf_sticky_reg;

    assign drop_inc = wr_ignored | sg_ovf | rx_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_reg   <= '0;
            ovf_sticky_reg <= 1'b0;
        end else begin
            if (drop_inc && (drop_cnt_reg != 16'hFFFF)) begin
                drop_cnt_reg <= drop_cnt_reg + 16'd1;
            end
            if (sg_ovf | rx_ovf) begin
                ovf_sticky_reg <= 1'b1;
            end
        end
    end

    assign drop_cnt   = drop_cnt_reg;
    assign ovf_sticky = ovf_sticky_reg;
endmodule

// File: doc/ingress_wrreq_regbank.md
# ingress_wrreq_regbank

Per-channel register bank sitting directly downstream of the ingress write-request parser. It consumes the `wr_req`/`wr_tdest`/`wr_tdata` strobe and stores SG-buffer and RX-transfer registers per direction and channel. Doorbell writes turn the stored registers into SG-descriptor and RX-transfer events, which are queued toward the TX/RX action modules. The upstream parser cannot be stalled (its ready is tied high), so this block never back-pressures and drops events only on queue overflow.

## Interface
- `CHANNEL_NUM`, default 16: number of implemented channels, 1..16.
- `EVQ_DEPTH`, default 4: depth of each event queue, power of two, at least 2.
- `clk` in, 1: system clock.
- `rst_n` in, 1: reset, asynchronous, active-low.
- `wr_req` in, 1: single-cycle write strobe, at most one per cycle.
- `wr_tdest` in, 10: [3:0] channel, [5:4] action (00 = TX, 01 = RX), [8:6] register code, [9] ignored.
- `wr_tdata` in, 32: write data.
- `sg_evt_valid` out, 1: SG event queue head valid.
- `sg_evt_rdy` in, 1: SG event consumer ready.
- `sg_evt_dir` out, 1: 0 = TX, 1 = RX.
- `sg_evt_chn` out, 4: channel.
- `sg_evt_addr` out, 64: {high, low} PC address.
- `sg_evt_len` out, 32: SG buffer length.
- `rx_evt_valid` out, 1: RX transfer event head valid.
- `rx_evt_rdy` in, 1: RX transfer consumer ready.
- `rx_evt_chn` out, 4: channel.
- `rx_evt_len` out, 32: transfer length.
- `rx_evt_offset` out, 31: `wr_tdata[30:0]` of the offset/last write.
- `rx_evt_last` out, 1: `wr_tdata[31]` of the offset/last write.
- `drop_cnt` out, 16: count of ignored writes plus overflowed events, saturating.
- `ovf_sticky` out, 1: set on any event-queue overflow, cleared only by reset.

## Operation
- Register code decode:
  - 000: transfer length.
  - 001: offset/last.
  - 011: SG length.
  - 100: SG low address.
  - 101: SG high address.
- Per (direction, channel) storage: `sg_len[32]` and `sg_lo[32]`. RX only: `xfer_len[32]`. All storage resets to 0.
- Valid writes, each applied on the `wr_req` cycle:
  - 011, either direction: update `sg_len`.
  - 100, either direction: update `sg_lo`.
  - 101, either direction: push an SG event {dir, chn, {wr_tdata, sg_lo}, sg_len}. `sg_lo` and `sg_len` are the values stored before this cycle. No high register is stored.
  - 000, RX only: update `xfer_len`.
  - 001, RX only: push an RX event {chn, xfer_len, wr_tdata[30:0], wr_tdata[31]}.
- Ignored writes: no storage change and no event; `drop_cnt` +1. A write is ignored when any of the following holds:
  - action is 10 or 11;
  - channel is at or above `CHANNEL_NUM`;
  - code is 010, 110 or 111;
  - code is 000 or 001 with action TX.
- Event queues: two independent FIFOs of depth `EVQ_DEPTH`. The output fields are the head entry. Pop occurs when `valid && rdy`.
- Overflow: a push is accepted when the queue is not full, or when it is full and a pop occurs in the same cycle. Otherwise the event is discarded, `drop_cnt` +1 and `ovf_sticky` is set.
- `drop_cnt` saturates at 0xFFFF. At most one increment per cycle, because there is at most one write per cycle.

## Timing
- Reset values: `sg_evt_valid`/`rx_evt_valid` = 0, all event fields 0, `drop_cnt` = 0, `ovf_sticky` = 0, queues empty.
- A storage update from a write in cycle N is visible to a doorbell write in cycle N+1. Back-to-back low-then-high writes therefore produce the new low address in the event.
- Event latency: doorbell `wr_req` in cycle N gives `*_evt_valid` high in cycle N+1 when the queue was empty. There is no combinational path from `wr_req` to outputs.
- Head fields are stable while `valid && !rdy`. After a pop, the next entry appears in the following cycle.
- Push to an empty queue with a simultaneous `rdy`: valid stays low that cycle. The entry appears in N+1 and is not lost.
- `rst_n` asserted mid-operation: queues flush, storage clears, and pending events are lost without counting.

## Test plan
- Write RX, ch 3: SG len 0x1000, low 0x8000_0000, high 0x1. Expect a single `sg_evt` one cycle after the high write, with dir 1, chn 3, addr 0x0000_0001_8000_0000, len 0x1000.
- Write RX, ch 5: transfer length 0x200, then offset/last 0x8000_0010. Expect `rx_evt` with chn 5, len 0x200, offset 0x10, last 1.
- Hold `sg_evt_rdy` = 0 and issue 5 TX high writes with `EVQ_DEPTH` = 4. Expect 4 queued events, `drop_cnt` = 1 and `ovf_sticky` = 1. Releasing ready drains the 4 events in order.
- Full queue plus a high write in the same cycle as a pop. Expect the push accepted, occupancy still 4 and `drop_cnt` unchanged.
- Issue four ignored writes: action 10; channel 15 with `CHANNEL_NUM` = 12; code 110; TX offset/last. Expect no events and `drop_cnt` = 4.
- Assert `rst_n` with 2 events queued. Expect valid low immediately. After release, a subsequent high write reports `sg_lo` = 0 and `sg_len` = 0.
